operand_shift_checker: RTL and testbench
========================================

Name: operand_shift_checker

Overview:
- Parametrised successor to the per-channel operand shift harness that feeds a multi-operand adder/compressor DUT.
- Holds N_CH operand registers of DEPTH bits each. Each register is filled by serial shift or by parallel load.
- Tracks fill state and computes a golden sum of all operands, delayed to match a DUT pipeline of DUT_LAT cycles.
- Compares the golden sum against the DUT result and counts mismatches. Sits between bench stimulus and the compressor under test.

Parameters:
N_CH, 17, number of operand channels (>=2)
DEPTH, 17, bits per operand / shift depth (>=2)
DUT_LAT, 0, DUT output latency in clk cycles (0..8)
CNT_W, 16, error counter width
SUM_W, DEPTH+$clog2(N_CH), derived golden sum width (17,17 -> 22); not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
shift_en  in  1  shift serial_in into all operands this cycle
serial_in  in  N_CH  bit i feeds operand i LSB
load_en  in  1  parallel load; has priority over shift_en
load_data  in  N_CH*DEPTH  operand i = load_data[i*DEPTH +: DEPTH]
operands  out  N_CH*DEPTH  registered operand array, drives DUT inputs
ops_valid  out  1  all DEPTH bits of every operand defined
dut_sum  in  SUM_W  DUT result
ref_sum  out  SUM_W  golden sum aligned with dut_sum
chk_valid  out  1  registered: compare result valid this cycle
mismatch  out  1  registered one-cycle pulse on compare failure
err_count  out  CNT_W  saturating mismatch count

Behaviour:
- Reset (rst=1 at edge): operands=0, fill_count=0, ops_valid=0, delay pipes cleared, chk_valid=0, mismatch=0, err_count=0. Reset overrides load_en and shift_en and aborts any partial fill.
- Update rule per edge, in priority order:
  - load_en=1: operand i <= load_data slice; fill_count <= DEPTH.
  - else shift_en=1: operand i <= {operand_i[DEPTH-2:0], serial_in[i]}; the MSB is discarded; fill_count <= min(fill_count+1, DEPTH), saturating.
  - else: hold.
- ops_valid = (fill_count==DEPTH), registered with fill_count. It stays 1 through further shifts; only rst clears it.
- Golden sum:
  - ref_now = unsigned sum of the N_CH current operand values, zero-extended to SUM_W. This is combinational from the registered operands and cannot overflow by construction.
  - ref_now and ops_valid pass through a DUT_LAT-stage register pipe. With DUT_LAT=0 the pipe is a wire.
  - ref_sum is the pipe output. For DUT_LAT>0, ref_sum is 0 after rst until the pipe refills.
- Compare: each cycle, cmp_ok = (ref_sum==dut_sum). At the next edge:
  - chk_valid <= delayed ops_valid;
  - mismatch <= delayed ops_valid & ~cmp_ok.
  - Net latency from an operand update to mismatch = DUT_LAT+1 cycles.
- err_count increments on each mismatch pulse and saturates at 2^CNT_W-1 with no wrap.
- Invalid operands (fill < DEPTH) are never compared, so no mismatch is possible before the first full fill.
- Simultaneous load_en and shift_en: load wins and serial_in is ignored that cycle.

Decomposition:
- Shared package cmp_bench_pkg: function clog2-based sum_w(n_ch, depth); localparam defaults for N_CH, DEPTH and DUT_LAT; typedef for the saturating counter width.
- One sub-module, delay_pipe (params WIDTH, LAT; clk, rst, d, q; LAT=0 pass-through). It is instantiated twice: for ref_now and for ops_valid.

Test Plan:
- Reset, then 16 shift cycles with all serial_in=1 -> ops_valid=0. 17th shift -> ops_valid=1; every operand=17'h1FFFF; ref_sum=17*131071=2228207 (22'h21FFEF).
- load_en with operand i = i (0..16) and dut_sum=136, DUT_LAT=0 -> next cycle chk_valid=1, mismatch=0, err_count=0.
- Same load with dut_sum=135 held -> mismatch pulses every valid cycle; err_count increments 1,2,3.
- DUT_LAT=2, load all-ones then load all-zeros, with a model DUT delayed 2 cycles -> no mismatch. Model DUT delayed 1 cycle -> exactly one mismatch, at the transition.
- load_en and shift_en together with serial_in=all 1, load_data=0 -> operands=0, fill_count=DEPTH.
- CNT_W=2 with a forced persistent mismatch -> err_count saturates at 3. rst asserted mid-fill after 5 shifts -> all outputs 0; the next 16 shifts leave ops_valid=0.

Source files
------------

// File: rtl/cmp_bench_pkg.sv
// Shared definitions for the operand shift checker slice.
// Holds the default channel/depth/latency/counter parameters, the golden
// sum width helper and the error-counter type used at the default width.
package cmp_bench_pkg;

    localparam int N_CH_DEF    = 17;
    localparam int DEPTH_DEF   = 17;
    localparam int DUT_LAT_DEF = 0;
    localparam int CNT_W_DEF   = 16;

    // Summing n_ch unsigned depth-bit values needs clog2(n_ch) extra bits.
    function automatic int sum_w(input int n_ch, input int depth);
        return depth + $clog2(n_ch);
    endfunction

    typedef logic [CNT_W_DEF-1:0] err_cnt_t;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-latency register pipe with synchronous clear.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high clear of every stage
//   d   - input word
//   q   - d delayed by LAT cycles (LAT=0 gives a plain wire)
module delay_pipe #(
    parameter int WIDTH = 1,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/operand_shift_checker.sv
// Operand shift checker: N_CH operand registers of DEPTH bits, filled by
// serial shift or parallel load, feeding a multi-operand adder under test.
// A golden sum of the operands is delayed by DUT_LAT cycles and compared to
// the DUT result; mismatches are pulsed and counted (saturating).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   shift_en    - shift serial_in[i] into the LSB of operand i
//   serial_in   - one serial bit per channel
//   load_en     - parallel load (wins over shift_en)
//   load_data   - operand i = load_data[i*DEPTH +: DEPTH]
//   operands    - registered operand array to the DUT
//   ops_valid   - every operand has all DEPTH bits defined
//   dut_sum     - DUT result
//   ref_sum     - golden sum aligned with dut_sum
//   chk_valid   - compare result valid this cycle
//   mismatch    - one-cycle pulse on compare failure
//   err_count   - saturating mismatch count
module operand_shift_checker
    import cmp_bench_pkg::*;
#(
    parameter int  N_CH    = N_CH_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  DUT_LAT = DUT_LAT_DEF,
    parameter int  CNT_W   = CNT_W_DEF,
    localparam int SUM_W   = sum_w(N_CH, DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [N_CH-1:0]       serial_in,
    input  logic                  load_en,
    input  logic [N_CH*DEPTH-1:0] load_data,
    output logic [N_CH*DEPTH-1:0] operands,
    output logic                  ops_valid,
    input  logic [SUM_W-1:0]      dut_sum,
    output logic [SUM_W-1:0]      ref_sum,
    output logic                  chk_valid,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      err_count
);

    localparam int                FILL_W    = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    logic [DEPTH-1:0]  ops_q [N_CH];
    logic [FILL_W-1:0] fill_count;
    logic [FILL_W-1:0] fill_next;
    logic [SUM_W-1:0]  ref_now;
    logic              valid_dly;
    logic              cmp_ok;

    always_comb begin
        fill_next = fill_count;
        if (load_en) begin
            fill_next = FILL_FULL;
        end else if (shift_en && (fill_count != FILL_FULL)) begin
            fill_next = fill_count + FILL_W'(1);
        end
    end

    // ops_valid is registered from fill_next so it changes on the same
    // edge as fill_count; once full it only drops on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) ops_q[i] <= '0;
            fill_count <= '0;
            ops_valid  <= 1'b0;
        end else begin
            if (load_en) begin
                for (int i = 0; i < N_CH; i++) ops_q[i] <= load_data[i*DEPTH +: DEPTH];
            end else if (shift_en) begin
                for (int i = 0; i < N_CH; i++) ops_q[i] <= {ops_q[i][DEPTH-2:0], serial_in[i]};
            end
            fill_count <= fill_next;
            ops_valid  <= (fill_next == FILL_FULL);
        end
    end

    always_comb begin
        operands = '0;
        for (int i = 0; i < N_CH; i++) operands[i*DEPTH +: DEPTH] = ops_q[i];
    end

    // SUM_W is sized so this accumulation cannot overflow.
    always_comb begin
        ref_now = '0;
        for (int i = 0; i < N_CH; i++) ref_now = ref_now + SUM_W'(ops_q[i]);
    end

    delay_pipe #(
        .WIDTH (SUM_W),
        .LAT   (DUT_LAT)
    ) u_ref_pipe (
        .clk (clk),
        .rst (rst),
        .d   (ref_now),
        .q   (ref_sum)
    );

    delay_pipe #(
        .WIDTH (1),
        .LAT   (DUT_LAT)
    ) u_valid_pipe (
        .clk (clk),
        .rst (rst),
        .d   (ops_valid),
        .q   (valid_dly)
    );

    assign cmp_ok = (ref_sum == dut_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            chk_valid <= valid_dly;
            mismatch  <= valid_dly & ~cmp_ok;
            if (valid_dly && !cmp_ok && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_shift_checker.sv
module tb_operand_shift_checker;

    localparam int N  = 17;
    localparam int D  = 17;
    localparam int SW = 22;
    localparam int NW = N * D;

    localparam int M_GOOD  = 0;
    localparam int M_LAG   = 1;
    localparam int M_CONST = 2;
    localparam int M_RAND  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          shift_en;
    logic [N-1:0]  serial_in;
    logic          load_en;
    logic [NW-1:0] load_data;

    logic [SW-1:0] ds   [2];
    logic [NW-1:0] opso [2];
    logic          opv  [2];
    logic [SW-1:0] rs   [2];
    logic          chv  [2];
    logic          mmo  [2];
    logic [15:0]   ec0;
    logic [1:0]    ec1;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    longint unsigned m_ops [N];
    int              m_fill;
    longint          hist_sum [$];
    bit              hist_val [$];
    bit              m_chk [2];
    bit              m_mm  [2];
    int              m_err [2];
    bit              model_live = 1'b0;
    int              mode  [2];
    logic [SW-1:0]   cval  [2];

    always #5 clk = ~clk;

    operand_shift_checker #(
        .N_CH(N), .DEPTH(D), .DUT_LAT(0), .CNT_W(16)
    ) u0 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
        .load_en(load_en), .load_data(load_data), .operands(opso[0]),
        .ops_valid(opv[0]), .dut_sum(ds[0]), .ref_sum(rs[0]),
        .chk_valid(chv[0]), .mismatch(mmo[0]), .err_count(ec0)
    );

    operand_shift_checker #(
        .N_CH(N), .DEPTH(D), .DUT_LAT(2), .CNT_W(2)
    ) u1 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
        .load_en(load_en), .load_data(load_data), .operands(opso[1]),
        .ops_valid(opv[1]), .dut_sum(ds[1]), .ref_sum(rs[1]),
        .chk_valid(chv[1]), .mismatch(mmo[1]), .err_count(ec1)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(m_ops[i]);
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_chk[k] = 1'b0;
                m_mm[k]  = 1'b0;
                m_err[k] = 0;
            end else begin
                m_chk[k] = hist_val[$-lat_of(k)];
                m_mm[k]  = m_chk[k] && (hist_sum[$-lat_of(k)] != longint'(ds[k]));
                if (m_mm[k] && m_err[k] < cmax_of(k)) m_err[k]++;
            end
        end
        if (rst) begin
            for (int i = 0; i < N; i++) m_ops[i] = 0;
            m_fill = 0;
        end else if (load_en) begin
            for (int i = 0; i < N; i++) m_ops[i] = longint'(load_data[i*D +: D]);
            m_fill = D;
        end else if (shift_en) begin
            for (int i = 0; i < N; i++)
                m_ops[i] = ((m_ops[i] * 2) + longint'(serial_in[i])) % (longint'(1) << D);
            if (m_fill < D) m_fill++;
        end
        if (rst) begin
            hist_sum.delete();
            hist_val.delete();
            for (int j = 0; j < 9; j++) begin
                hist_sum.push_back(0);
                hist_val.push_back(1'b0);
            end
            model_live = 1'b1;
        end else begin
            hist_sum.push_back(model_sum());
            hist_val.push_back(m_fill == D);
            if (hist_sum.size() > 12) begin
                void'(hist_sum.pop_front());
                void'(hist_val.pop_front());
            end
        end
    endtask

    task automatic compare_all();
        logic [NW-1:0] exp_ops;
        exp_ops = '0;
        for (int i = 0; i < N; i++) exp_ops[i*D +: D] = D'(m_ops[i]);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("operands%0d", k), opso[k], exp_ops);
            chk($sformatf("ops_valid%0d", k), NW'(opv[k]), NW'(m_fill == D));
            chk($sformatf("ref_sum%0d", k), NW'(rs[k]), NW'(hist_sum[$-lat_of(k)]));
            chk($sformatf("chk_valid%0d", k), NW'(chv[k]), NW'(m_chk[k]));
            chk($sformatf("mismatch%0d", k), NW'(mmo[k]), NW'(m_mm[k]));
        end
        chk("err_count0", NW'(ec0), NW'(m_err[0]));
        chk("err_count1", NW'(ec1), NW'(m_err[1]));
    endtask

    task automatic drive_dut_sums();
        logic [SW-1:0] flip;
        for (int k = 0; k < 2; k++) begin
            case (mode[k])
                M_LAG:   ds[k] = SW'(hist_sum[$-(lat_of(k) - 1)]);
                M_CONST: ds[k] = cval[k];
                M_RAND: begin
                    ds[k] = SW'(hist_sum[$-lat_of(k)]);
                    if ($urandom_range(3) == 0) begin
                        flip = '0;
                        flip[$urandom_range(SW-1)] = 1'b1;
                        ds[k] = ds[k] ^ flip;
                    end
                end
                default: ds[k] = SW'(hist_sum[$-lat_of(k)]);
            endcase
        end
    endtask

    // Model + compare process: model advances at each rising edge, outputs
    // are checked 1 time unit later, and the stand-in DUT results are
    // refreshed just after the falling edge.
    initial begin
        for (int j = 0; j < 9; j++) begin
            hist_sum.push_back(0);
            hist_val.push_back(1'b0);
        end
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            if (model_live) compare_all();
            @(negedge clk);
            #1;
            drive_dut_sums();
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_load_all(input logic [D-1:0] v);
        for (int i = 0; i < N; i++) load_data[i*D +: D] = v;
    endtask

    initial begin
        rst       = 1'b1;
        shift_en  = 1'b0;
        serial_in = '0;
        load_en   = 1'b0;
        load_data = '0;
        ds[0]     = '0;
        ds[1]     = '0;
        mode[0]   = M_GOOD;
        mode[1]   = M_GOOD;
        cval[0]   = '0;
        cval[1]   = '0;
        tick();
        tick();
        chk("reset_ref_sum1", NW'(rs[1]), NW'(0));
        chk("reset_err_count0", NW'(ec0), NW'(0));
        rst = 1'b0;

        // serial fill with all ones
        shift_en  = 1'b1;
        serial_in = '1;
        repeat (16) tick();
        chk("fill16_ops_valid", NW'(opv[0]), NW'(0));
        tick();
        chk("fill17_ops_valid", NW'(opv[0]), NW'(1));
        chk("fill17_operands", opso[0], {NW{1'b1}});
        chk("fill17_ref_sum", NW'(rs[0]), NW'(22'h21FFEF));
        chk("fill17_ref_sum_dec", NW'(rs[0]), NW'(2228207));
        shift_en = 1'b0;

        // parallel load operand i = i, DUT returns the right sum
        for (int i = 0; i < N; i++) load_data[i*D +: D] = D'(i);
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        mode[0] = M_CONST;
        cval[0] = SW'(136);
        tick();
        chk("load_ref_sum", NW'(rs[0]), NW'(136));
        chk("load_chk_valid", NW'(chv[0]), NW'(1));
        chk("load_mismatch", NW'(mmo[0]), NW'(0));
        chk("load_err_count", NW'(ec0), NW'(0));

        // persistent wrong DUT result
        cval[0] = SW'(135);
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("bad_sum_mismatch", NW'(mmo[0]), NW'(1));
            chk("bad_sum_err_count", NW'(ec0), NW'(n));
        end
        mode[0] = M_GOOD;

        // latency-2 instance with a correctly delayed DUT
        load_en = 1'b1;
        set_load_all('1);
        repeat (4) tick();
        set_load_all('0);
        repeat (4) tick();
        set_load_all('1);
        repeat (4) tick();
        chk("lat2_good_err_count", NW'(ec1), NW'(0));
        // DUT that is one cycle early: exactly one mismatch at the step
        mode[1] = M_LAG;
        repeat (2) tick();
        set_load_all('0);
        repeat (5) tick();
        chk("lat2_lag_err_count", NW'(ec1), NW'(1));

        // load and shift together: load wins
        shift_en  = 1'b1;
        serial_in = '1;
        load_data = '0;
        tick();
        chk("load_shift_operands", opso[0], NW'(0));
        chk("load_shift_ops_valid", NW'(opv[0]), NW'(1));
        load_en  = 1'b0;
        shift_en = 1'b0;

        // saturation of the 2-bit counter
        mode[1] = M_CONST;
        cval[1] = SW'(1);
        repeat (5) tick();
        chk("sat_err_count1", NW'(ec1), NW'(3));
        chk("sat_mismatch1", NW'(mmo[1]), NW'(1));

        // reset in the middle of a fill
        mode[1]  = M_GOOD;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        shift_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            serial_in = N'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("midrst_operands", opso[0], NW'(0));
        chk("midrst_ops_valid", NW'(opv[0]), NW'(0));
        chk("midrst_ref_sum1", NW'(rs[1]), NW'(0));
        chk("midrst_chk_valid1", NW'(chv[1]), NW'(0));
        chk("midrst_err_count0", NW'(ec0), NW'(0));
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            serial_in = N'($urandom);
            tick();
        end
        chk("refill16_ops_valid", NW'(opv[0]), NW'(0));
        tick();
        chk("refill17_ops_valid", NW'(opv[0]), NW'(1));
        shift_en = 1'b0;

        // randomized traffic
        mode[0] = M_RAND;
        mode[1] = M_RAND;
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(59) == 0);
            load_en   = ($urandom_range(5) == 0);
            shift_en  = ($urandom_range(1) == 0);
            serial_in = N'($urandom);
            for (int i = 0; i < N; i++) load_data[i*D +: D] = D'($urandom);
            tick();
        end
        rst      = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
